// File: rtl/axis_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_adder_pkg
//  Description : Shared types and constants for the AXI-Stream adder arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_adder_pkg;

    localparam int NUM_REQ = 2;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : Registered unsigned adder, result zero-extended by one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0] r_sum_q;
    logic [WIDTH:0] w_sum_d;

    // Compute a new sum only when enabled, otherwise hold the last result
    always_comb begin
        w_sum_d = r_sum_q;
        if (i_en) begin
            w_sum_d = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    // Result register, cleared by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_q <= '0;
        end else begin
            r_sum_q <= w_sum_d;
        end
    end

    assign o_sum = r_sum_q;

endmodule
`default_nettype wire

// File: rtl/adder_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_grant
//  Description : Two-way round-robin grant selector with frame lock; owns the
//                last-grant pointer (requester 0 wins first after reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_grant
    import axis_adder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_lock,
    input  logic               i_lock_id,
    input  logic               i_upd,
    input  logic               i_upd_src,
    output logic               o_gnt_vld,
    output logic               o_gnt_id
);

    logic r_last_grant_q;
    logic w_last_grant_d;

    // Locked owner first, then alternate on contention, else the lone requester
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_id  = 1'b0;
        if (i_lock) begin
            o_gnt_vld = i_valid[i_lock_id];
            o_gnt_id  = i_lock_id;
        end else if (i_valid[0] && i_valid[1]) begin
            o_gnt_vld = 1'b1;
            o_gnt_id  = ~r_last_grant_q;
        end else if (i_valid[0]) begin
            o_gnt_vld = 1'b1;
            o_gnt_id  = 1'b0;
        end else if (i_valid[1]) begin
            o_gnt_vld = 1'b1;
            o_gnt_id  = 1'b1;
        end
    end

    // The pointer only moves when a frame completes
    always_comb begin
        w_last_grant_d = r_last_grant_q;
        if (i_upd) begin
            w_last_grant_d = i_upd_src;
        end
    end

    // Pointer register; reset value 1 so requester 0 is favoured first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant_q <= 1'b1;
        end else begin
            r_last_grant_q <= w_last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_adder_arbiter
//  Description : Shares one registered adder between two AXI-Stream operand
//                requesters with frame-locked round-robin arbitration.
//                Optional statistics ports: AXIS_ADDER_ARBITER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_adder_arbiter
    import axis_adder_pkg::*;
#(
    parameter int c_WIDTH  = 4,
    parameter int ID_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*c_WIDTH-1:0] s0_axis_tdata,
    input  logic                 s0_axis_tvalid,
    output logic                 s0_axis_tready,
    input  logic                 s0_axis_tlast,
    input  logic [ID_WIDTH-1:0]  s0_axis_tid,
    input  logic [2*c_WIDTH-1:0] s1_axis_tdata,
    input  logic                 s1_axis_tvalid,
    output logic                 s1_axis_tready,
    input  logic                 s1_axis_tlast,
    input  logic [ID_WIDTH-1:0]  s1_axis_tid,
    output logic [c_WIDTH:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [ID_WIDTH-1:0]  m_axis_tid,
    output logic                 m_axis_tdest,
    output logic                 busy
`ifdef AXIS_ADDER_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_beats0,
    output logic [STAT_W-1:0]    stat_beats1,
    output logic [STAT_W-1:0]    stat_carry
`endif
);

    state_t                r_state_q, w_state_d;
    logic                  r_lock_q, w_lock_d;
    logic                  r_lock_id_q, w_lock_id_d;
    logic [c_WIDTH-1:0]    r_a_q, w_a_d;
    logic [c_WIDTH-1:0]    r_b_q, w_b_d;
    logic [ID_WIDTH-1:0]   r_tid_q, w_tid_d;
    logic                  r_tlast_q, w_tlast_d;
    logic                  r_tdest_q, w_tdest_d;
    logic                  r_tvalid_q, w_tvalid_d;

    logic                  w_gnt_vld, w_gnt_id;
    logic                  w_idle, w_calc;
    logic                  w_ready0, w_ready1;
    logic                  w_in_hs, w_out_hs;
    logic [2*c_WIDTH-1:0]  w_sel_data;
    logic [ID_WIDTH-1:0]   w_sel_tid;
    logic                  w_sel_tlast;
    logic [c_WIDTH:0]      w_sum;

    assign w_idle = (r_state_q == IDLE);
    assign w_calc = (r_state_q == CALC);

    adder_rr_grant u_grant (
        .clk       (clk),
        .rst       (rst),
        .i_valid   ({s1_axis_tvalid, s0_axis_tvalid}),
        .i_lock    (r_lock_q),
        .i_lock_id (r_lock_id_q),
        .i_upd     (w_in_hs & w_sel_tlast),
        .i_upd_src (w_gnt_id),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    // Ready only for the granted requester while idle; held low during reset
    assign w_ready0 = rst & w_idle & w_gnt_vld & ~w_gnt_id;
    assign w_ready1 = rst & w_idle & w_gnt_vld &  w_gnt_id;
    assign w_in_hs  = (w_ready0 & s0_axis_tvalid) | (w_ready1 & s1_axis_tvalid);
    assign w_out_hs = r_tvalid_q & m_axis_tready;

    assign w_sel_data  = w_gnt_id ? s1_axis_tdata  : s0_axis_tdata;
    assign w_sel_tid   = w_gnt_id ? s1_axis_tid    : s0_axis_tid;
    assign w_sel_tlast = w_gnt_id ? s1_axis_tlast  : s0_axis_tlast;

    adder #(
        .WIDTH (c_WIDTH)
    ) u_adder (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_calc),
        .i_a   (r_a_q),
        .i_b   (r_b_q),
        .o_sum (w_sum)
    );

    // Beat sequencer: capture operands, wait one cycle for the sum, present it
    always_comb begin
        w_state_d   = r_state_q;
        w_lock_d    = r_lock_q;
        w_lock_id_d = r_lock_id_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_tid_d     = r_tid_q;
        w_tlast_d   = r_tlast_q;
        w_tdest_d   = r_tdest_q;
        w_tvalid_d  = r_tvalid_q;
        case (r_state_q)
            IDLE: begin
                if (w_in_hs) begin
                    w_a_d       = w_sel_data[c_WIDTH-1:0];
                    w_b_d       = w_sel_data[2*c_WIDTH-1:c_WIDTH];
                    w_tid_d     = w_sel_tid;
                    w_tlast_d   = w_sel_tlast;
                    w_tdest_d   = w_gnt_id;
                    w_lock_d    = ~w_sel_tlast;
                    w_lock_id_d = w_sel_tlast ? r_lock_id_q : w_gnt_id;
                    w_state_d   = CALC;
                end
            end
            CALC: begin
                w_tvalid_d = 1'b1;
                w_state_d  = OUT;
            end
            OUT: begin
                if (w_out_hs) begin
                    w_tvalid_d = 1'b0;
                    w_state_d  = IDLE;
                end
            end
            default: begin
                w_tvalid_d = 1'b0;
                w_state_d  = IDLE;
            end
        endcase
    end

    // State, lock and beat registers; reset discards any in-flight beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= IDLE;
            r_lock_q    <= 1'b0;
            r_lock_id_q <= 1'b0;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_tid_q     <= '0;
            r_tlast_q   <= 1'b0;
            r_tdest_q   <= 1'b0;
            r_tvalid_q  <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_lock_q    <= w_lock_d;
            r_lock_id_q <= w_lock_id_d;
            r_a_q       <= w_a_d;
            r_b_q       <= w_b_d;
            r_tid_q     <= w_tid_d;
            r_tlast_q   <= w_tlast_d;
            r_tdest_q   <= w_tdest_d;
            r_tvalid_q  <= w_tvalid_d;
        end
    end

    assign s0_axis_tready = w_ready0;
    assign s1_axis_tready = w_ready1;
    assign m_axis_tdata   = w_sum;
    assign m_axis_tvalid  = r_tvalid_q;
    assign m_axis_tlast   = r_tlast_q;
    assign m_axis_tid     = r_tid_q;
    assign m_axis_tdest   = r_tdest_q;
    assign busy           = ~w_idle | r_lock_q;

`ifdef AXIS_ADDER_ARBITER_STATS_EN
    localparam logic [STAT_W-1:0] c_STAT_ONE = 1;

    logic [STAT_W-1:0] r_beats0_q, w_beats0_d;
    logic [STAT_W-1:0] r_beats1_q, w_beats1_d;
    logic [STAT_W-1:0] r_carry_q,  w_carry_d;

    // Saturating counters: accepted beats per requester, delivered carry-out results
    always_comb begin
        w_beats0_d = r_beats0_q;
        w_beats1_d = r_beats1_q;
        w_carry_d  = r_carry_q;
        if (w_in_hs && !w_gnt_id && (r_beats0_q != '1)) begin
            w_beats0_d = r_beats0_q + c_STAT_ONE;
        end
        if (w_in_hs && w_gnt_id && (r_beats1_q != '1)) begin
            w_beats1_d = r_beats1_q + c_STAT_ONE;
        end
        if (w_out_hs && w_sum[c_WIDTH] && (r_carry_q != '1)) begin
            w_carry_d = r_carry_q + c_STAT_ONE;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beats0_q <= '0;
            r_beats1_q <= '0;
            r_carry_q  <= '0;
        end else begin
            r_beats0_q <= w_beats0_d;
            r_beats1_q <= w_beats1_d;
            r_carry_q  <= w_carry_d;
        end
    end

    assign stat_beats0 = r_beats0_q;
    assign stat_beats1 = r_beats1_q;
    assign stat_carry  = r_carry_q;
`endif

endmodule
`default_nettype wire

// File: doc/axis_adder_arbiter.md
Name: axis_adder_arbiter

Overview:
- Shares one registered `adder` instance between two AXI-Stream operand requesters.
- Round-robin arbitration with frame locking: a granted requester keeps the adder until its tlast beat.
- Sequences each beat through operand capture, add and result handshake, and tags each result with its source.
- Sits between the operand FIFOs (`axis_fifo`) and the downstream result stream.

Parameters:
- c_WIDTH, 4, operand width; result width is c_WIDTH+1.
- ID_WIDTH, 8, tid width passed through from the requester to the result.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s0_axis_tdata  in  2*c_WIDTH  requester 0 operands {b,a}; a = [c_WIDTH-1:0].
- s0_axis_tvalid  in  1  requester 0 valid.
- s0_axis_tready  out  1  requester 0 ready.
- s0_axis_tlast  in  1  requester 0 end of frame.
- s0_axis_tid  in  ID_WIDTH  requester 0 id.
- s1_axis_tdata, s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tid: same as s0, for requester 1.
- m_axis_tdata  out  c_WIDTH+1  sum a+b.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  copy of the accepted beat's tlast.
- m_axis_tid  out  ID_WIDTH  copy of the accepted beat's tid.
- m_axis_tdest  out  1  source requester index.
- busy  out  1  state != IDLE or lock held.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, lock=0, last_grant=1 (requester 0 wins first).
  - All m_axis_* outputs = 0; s*_axis_tready = 0; operand registers = 0.
  - An in-flight beat is discarded and no partial result is emitted.
  - Release is synchronous to clk.
- FSM states: IDLE, CALC, OUT.
- IDLE, grant selection:
  - If lock=1, only the locked requester is eligible.
  - Else if both tvalid are high, grant = ~last_grant.
  - Else if one tvalid is high, that requester is granted.
  - Else no grant.
- IDLE, ready and accept:
  - sN_axis_tready = 1 only for the granted requester; it is combinational from tvalid and the state registers.
  - The other requester's tready = 0.
  - On handshake: latch a, b, tid, tlast and source into registers, drive the adder inputs, go to CALC.
- CALC:
  - One cycle while the adder registers result = a + b, zero-extended to c_WIDTH+1.
  - No overflow or wrap is possible.
  - Next state is OUT.
- OUT:
  - m_axis_tvalid = 1; data, tid, tlast and tdest are held stable until m_axis_tready = 1.
  - On handshake: go to IDLE and clear m_axis_tvalid.
- Lock and pointer update, at input handshake:
  - If tlast=0: lock=1 and lock_id = source.
  - If tlast=1: lock=0 and last_grant = source.
- Timing:
  - Latency from input handshake (cycle N) to m_axis_tvalid is cycle N+2.
  - Peak throughput is 1 beat per 3 cycles.
- Boundary conditions:
  - Locked requester drops tvalid mid-frame: the adder stays idle and the other requester is not served; lock persists.
  - Both requesters valid at the same time: strict alternation per frame.
  - Backpressure in OUT of any length: no input is accepted.
  - m_axis_tready high before tvalid: ignored.

Optional Feature:
- Macro AXIS_ADDER_ARBITER_STATS_EN.
- When defined:
  - Adds outputs stat_beats0 and stat_beats1 (16 bits each): per-requester accepted-beat counters, saturating at 0xFFFF.
  - Adds output stat_carry (16 bits, saturating): counts results with MSB=1.
  - All three reset to 0.
- When undefined: these ports and their logic are absent.

Decomposition:
- Package axis_adder_pkg holds:
  - the state enum (IDLE=2'd0, CALC=2'd1, OUT=2'd2);
  - the requester count constant NUM_REQ=2;
  - the stat counter width constant STAT_W=16.
- Natural sub-module: adder_rr_grant, a combinational grant selector with lock, plus the last_grant register.
- The existing `adder` is instantiated as is.

Test Plan:
- Reset release, s0 beat a=3, b=5, tlast=1, tid=0x11 -> m_axis_tdata=8, tdest=0, tid=0x11 at N+2; s0_tready low in CALC and OUT.
- s0 and s1 valid continuously, every beat tlast=1 -> results alternate tdest 0,1,0,1; requester 0 goes first after reset.
- s1 sends a 3-beat frame (tlast on the third beat) while s0 is valid throughout -> three tdest=1 results, then s0 is granted.
- a=15, b=15 with c_WIDTH=4 -> m_axis_tdata=5'd30; with STATS_EN, stat_carry increments by 1.
- m_axis_tready held low for 10 cycles in OUT -> output stays stable, no input accepted; release gives exactly one transfer.
- rst asserted during CALC -> all outputs 0 immediately, no result emitted; after release requester 0 is granted first.
